// File: rtl/uart_fifo_pkg.sv
// Shared constants and types for the UART receive FIFO and its drain engine.
package uart_fifo_pkg;
  localparam int FIFO_RD_LATENCY = 2;
  localparam int FIFO_DEPTH      = 128;
  localparam int UART_DATA_W     = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_drain_outbuf.sv
// Circular output buffer for the drain engine: push from FIFO capture, pop on host transfer.
module uart_drain_outbuf
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = UART_DATA_W,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CW-1:0]     count,
  output logic              valid,
  output logic [DATA_W-1:0] head
);
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PW-1:0]                wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      // Push into a full buffer cannot happen: the issue credit reserves a slot per strobe.
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign valid = (count != '0);
  assign head  = mem[rd_ptr];
endmodule

// File: rtl/uart_rx_fifo_drain.sv
// Drain engine for the UART RX FIFO: credit-based read strobes, latency tracking, valid/ready output.
// Optional flush port and discard tagging when UART_RX_FIFO_FLUSH_EN is defined.
module uart_rx_fifo_drain
  import uart_fifo_pkg::*;
#(
  parameter int RD_LATENCY = FIFO_RD_LATENCY,
  parameter int OUT_DEPTH  = 2,
  parameter int DATA_W     = UART_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
`ifdef UART_RX_FIFO_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read_n,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic [1:0]        inflight
);
  localparam int CW   = $clog2(OUT_DEPTH + 1);
  localparam int IMAX = (OUT_DEPTH < 3) ? OUT_DEPTH : 3;

  logic [RD_LATENCY-1:0] trk;
  logic [7:0]            pend;
  logic [CW-1:0]         occ;
  logic                  credit_ok, issue, capture, buf_valid, pop, clear;

  always_comb begin
    pend = '0;
    for (int i = 0; i < RD_LATENCY; i++) pend = pend + 8'(trk[i]);
  end

  assign inflight  = (pend > 8'(IMAX)) ? 2'(IMAX) : pend[1:0];
  assign credit_ok = (8'(occ) + pend) < 8'(OUT_DEPTH);

`ifdef UART_RX_FIFO_FLUSH_EN
  // Strobes in flight across a flush carry a discard tag so their late data is dropped.
  logic [RD_LATENCY-1:0] disc;

  always_ff @(posedge clock) begin
    if (reset)      disc <= '0;
    else if (flush) disc <= '1;
    else            disc <= disc << 1;
  end

  assign issue    = !reset && !fifo_empty && (flush || credit_ok);
  assign capture  = trk[RD_LATENCY-1] && !disc[RD_LATENCY-1] && !flush;
  assign rx_valid = buf_valid && !flush;
  assign clear    = flush;
`else
  assign issue    = !reset && !fifo_empty && credit_ok;
  assign capture  = trk[RD_LATENCY-1];
  assign rx_valid = buf_valid;
  assign clear    = 1'b0;
`endif

  assign fifo_read_n = !issue;
  assign pop         = rx_valid && rx_ready;

  always_ff @(posedge clock) begin
    if (reset) trk <= '0;
    else       trk <= (trk << 1) | RD_LATENCY'(issue);
  end

  uart_drain_outbuf #(
    .DEPTH  (OUT_DEPTH),
    .DATA_W (DATA_W)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .push      (capture),
    .push_data (fifo_data),
    .pop       (pop),
    .count     (occ),
    .valid     (buf_valid),
    .head      (rx_data)
  );
endmodule

// File: tb/tb_uart_rx_fifo_drain.sv
// Directed bench for uart_rx_fifo_drain with a two-cycle-latency FIFO model and an order scoreboard.
module tb_uart_rx_fifo_drain;
  import uart_fifo_pkg::*;

  localparam int OUT_DEPTH = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       fifo_empty;
  uart_byte_t fifo_data;
  logic       fifo_read_n;
  logic       rx_valid;
  uart_byte_t rx_data;
  logic       rx_ready;
  logic [1:0] inflight;
`ifdef UART_RX_FIFO_FLUSH_EN
  logic       flush = 1'b0;
`endif

  always #5 clock = ~clock;

  uart_rx_fifo_drain #(
    .RD_LATENCY (2),
    .OUT_DEPTH  (OUT_DEPTH),
    .DATA_W     (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
`ifdef UART_RX_FIFO_FLUSH_EN
    .flush       (flush),
`endif
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_read_n (fifo_read_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .inflight    (inflight)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         n_deliv = 0;
  uart_byte_t fq[$];
  uart_byte_t exp_q[$];
  uart_byte_t st1;
  logic       s_rdn, s_rxv, s_strobe, s_xfer;
  uart_byte_t s_rxd;
  logic [1:0] s_inf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input uart_byte_t b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample at the falling edge, then advance the FIFO model just after the rising edge.
  task automatic tick();
    uart_byte_t b;
    logic       fl;
    b  = 8'hEE;
`ifdef UART_RX_FIFO_FLUSH_EN
    fl = flush;
`else
    fl = 1'b0;
`endif
    @(negedge clock);
    s_rdn    = fifo_read_n;
    s_rxv    = rx_valid;
    s_rxd    = rx_data;
    s_inf    = inflight;
    s_strobe = !fifo_read_n;
    s_xfer   = rx_valid && rx_ready;
    if (s_xfer) begin
      if (exp_q.size() == 0) chk("order_extra", 32'(rx_data), 32'h100);
      else                   chk("order", 32'(rx_data), 32'(exp_q.pop_front()));
      n_deliv++;
    end
    if (s_strobe) begin
      chk("strobe_nonempty", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) b = fq.pop_front();
    end
    if (reset || fl)   exp_q.delete();
    else if (s_strobe) exp_q.push_back(b);
    chk("credit", 32'(exp_q.size() <= OUT_DEPTH), 32'd1);
    @(posedge clock);
    #1;
    fifo_data  = st1;
    st1        = s_strobe ? b : 8'hEE;
    fifo_empty = (fq.size() == 0);
  endtask

  initial begin
    int d0, ns;
    reset = 1'b1; rx_ready = 1'b0; fifo_empty = 1'b1; fifo_data = 8'hEE; st1 = 8'hEE;
    repeat (3) tick();
    // reset state, with a non-empty FIFO to show reset blocks strobes
    wr(8'h99);
    tick();
    chk("rst_read_n", 32'(s_rdn), 32'd1);
    chk("rst_valid", 32'(s_rxv), 32'd0);
    chk("rst_data", 32'(s_rxd), 32'd0);
    chk("rst_inflight", 32'(s_inf), 32'd0);
    fq.delete(); fifo_empty = 1'b1;
    reset = 1'b0;

    // 1: empty FIFO, nothing happens
    repeat (20) begin
      tick();
      chk("idle_read_n", 32'(s_rdn), 32'd1);
      chk("idle_valid", 32'(s_rxv), 32'd0);
      chk("idle_inflight", 32'(s_inf), 32'd0);
    end

    // 2: single byte, strobe latency and first-valid cycle
    rx_ready = 1'b1;
    wr(8'h41);
    tick(); chk("t2_strobe", 32'(s_rdn), 32'd0);
    tick(); chk("t2_single", 32'(s_rdn), 32'd1); chk("t2_inf1", 32'(s_inf), 32'd1);
    tick(); chk("t2_early", 32'(s_rxv), 32'd0); chk("t2_inf2", 32'(s_inf), 32'd1);
    tick(); chk("t2_valid", 32'(s_rxv), 32'd1); chk("t2_data", 32'(s_rxd), 32'h41);
            chk("t2_inf3", 32'(s_inf), 32'd0);
    tick(); chk("t2_gone", 32'(s_rxv), 32'd0);

    // 3: back-pressure holds head and limits strobes to the buffer depth
    rx_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr(8'(i));
    ns = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_strobe) ns++;
      if (i >= 4) begin
        chk("t3_valid", 32'(s_rxv), 32'd1);
        chk("t3_hold", 32'(s_rxd), 32'h00);
      end
    end
    chk("t3_strobes", 32'(ns), 32'(OUT_DEPTH));
    rx_ready = 1'b1;
    d0 = n_deliv;
    for (int k = 0; k < 200 && (n_deliv - d0) < 16; k++) tick();
    chk("t3_count", 32'(n_deliv - d0), 32'd16);
    chk("t3_fifo_drained", 32'(fq.size()), 32'd0);

    // 4: 128 bytes with random ready
    for (int i = 0; i < 128; i++) wr(8'(i * 7 + 3));
    d0 = n_deliv;
    for (int k = 0; k < 4000 && (n_deliv - d0) < 128; k++) begin
      rx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("t4_count", 32'(n_deliv - d0), 32'd128);

    // 5: reset with two strobes in flight
    rx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(8'h60 + 8'(i));
    tick(); chk("t5_strobe0", 32'(s_strobe), 32'd1);
    tick(); chk("t5_strobe1", 32'(s_strobe), 32'd1);
    reset = 1'b1;
    tick(); chk("t5_inf_pre", 32'(s_inf), 32'd2); chk("t5_rst_rdn", 32'(s_rdn), 32'd1);
    reset = 1'b0;
    tick(); chk("t5_valid", 32'(s_rxv), 32'd0); chk("t5_inf", 32'(s_inf), 32'd0);
    rx_ready = 1'b1;
    s_xfer = 1'b0;
    for (int k = 0; k < 20 && !s_xfer; k++) tick();
    chk("t5_next_byte", 32'(s_xfer ? s_rxd : 8'hEE), 32'h62);
    for (int k = 0; k < 100 && (fq.size() != 0 || exp_q.size() != 0); k++) tick();
    chk("t5_drained", 32'(exp_q.size() + fq.size()), 32'd0);

`ifdef UART_RX_FIFO_FLUSH_EN
    // 6: flush discards everything, then normal operation resumes
    for (int i = 0; i < 10; i++) wr(8'hA0 + 8'(i));
    flush = 1'b1;
    repeat (15) begin
      tick();
      chk("t6_flush_valid", 32'(s_rxv), 32'd0);
    end
    flush = 1'b0;
    repeat (4) begin
      tick();
      chk("t6_post_valid", 32'(s_rxv), 32'd0);
    end
    chk("t6_empty", 32'(fifo_empty), 32'd1);
    wr(8'h55);
    s_xfer = 1'b0;
    for (int k = 0; k < 20 && !s_xfer; k++) tick();
    chk("t6_new_byte", 32'(s_xfer ? s_rxd : 8'hEE), 32'h55);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo_drain.md
Name: uart_rx_fifo_drain

Overview:
Reader/drain engine for the UART 128x8 receive FIFO.
- Issues active-low single-cycle read strobes to the FIFO control and tracks each strobe through the FIFO's fixed two-cycle read latency.
- Captures returned bytes into a small output buffer and presents them on a valid/ready stream to the host-side register or APB logic.
- Sits between the FIFO read port and the host interface; it is the consumer counterpart of the receiver that writes the FIFO.

Parameters:
- RD_LATENCY, 2: cycles from the strobe cycle to the cycle in which the byte is visible on fifo_data (fixed by the FIFO).
- OUT_DEPTH, 2: output buffer entries (2..4).
- DATA_W, 8: byte width.

Ports:
- clock, in, 1: system clock; the FIFO also runs on this clock.
- reset, in, 1: synchronous, active-high reset.
- fifo_empty, in, 1: FIFO empty flag; current-cycle accurate.
- fifo_data, in, DATA_W: FIFO registered output data.
- fifo_read_n, out, 1: active-low read strobe; combinational from registered state and fifo_empty.
- rx_valid, out, 1: head byte available.
- rx_data, out, DATA_W: head byte.
- rx_ready, in, 1: consumer accepts the head byte; a transfer occurs when rx_valid && rx_ready.
- inflight, out, 2: number of strobes issued whose data has not yet been captured (debug/status).

Behaviour:
- Reset, synchronous, active-high: buffer empty, inflight=0, issue shift register cleared, rx_valid=0, rx_data=0, fifo_read_n=1. A reset mid-operation discards any in-flight strobes; their FIFO data is never captured.
- Issue rule: fifo_read_n=0 in cycle c iff !reset && !fifo_empty && (occupancy + inflight) < OUT_DEPTH, where occupancy and inflight are the cycle-c register values.
  - Back-to-back strobes are allowed. fifo_empty already reflects a strobe issued in c-1, because the FIFO counter updates at that edge.
- Tracking: a shift register of RD_LATENCY bits; bit 0 is loaded with the issue decision.
  - A byte is captured from fifo_data in the cycle where the tail bit is 1.
  - Capture is at the edge ending cycle c+RD_LATENCY. The earliest rx_valid is cycle c+3.
- inflight is the popcount of the shift register, with a maximum of OUT_DEPTH.
- Output buffer: circular, OUT_DEPTH entries, with wr_ptr, rd_ptr and an occupancy counter of width clog2(OUT_DEPTH+1).
  - Pointers wrap modulo OUT_DEPTH.
  - Simultaneous capture and transfer leaves occupancy unchanged and both pointers advance.
- Overflow is impossible by the credit rule. The bench asserts occupancy + inflight <= OUT_DEPTH every cycle.
- rx_valid = (occupancy != 0); rx_data = the entry at rd_ptr. rx_data is held stable while rx_valid && !rx_ready.
- Data order is strictly FIFO order. No byte is duplicated or dropped.
- fifo_empty rising while strobes are in flight has no effect on them; they complete normally.
- Steady-state throughput: with rx_ready held at 1 and OUT_DEPTH >= RD_LATENCY+1, one byte per cycle is transferred. With OUT_DEPTH=2 the throughput is 2 bytes per 3 cycles.

Optional Feature:
Macro: UART_RX_FIFO_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - While flush=1, rx_valid is forced to 0.
  - Strobes issue whenever !fifo_empty, with the credit check bypassed.
  - Captured bytes and buffered bytes are discarded: occupancy is cleared on every flush cycle and captures are dropped.
  - After flush deasserts, in-flight strobes still pending are dropped via a discard tag carried in the shift register.
  - Normal operation resumes with an empty buffer.
- Undefined: no flush port and no tag bits; behaviour is exactly as above.

Decomposition:
- Shared package uart_fifo_pkg holds:
  - constants FIFO_RD_LATENCY=2, FIFO_DEPTH=128, UART_DATA_W=8;
  - typedef uart_byte_t (logic [7:0]).
- One natural sub-module, uart_drain_outbuf: the OUT_DEPTH circular buffer with its occupancy counter and a push/pop interface. The top level holds the issue logic and the latency shift register.

Test Plan:
1. Reset, then fifo_empty=1 for 20 cycles -> fifo_read_n stays 1, rx_valid stays 0, inflight=0.
2. Model FIFO preloaded with 0x41; strobe in cycle 5 -> fifo_read_n=0 only in cycle 5, rx_valid=1 in cycle 8 with rx_data=0x41; rx_ready=1 -> rx_valid=0 in cycle 9.
3. Model FIFO holding 0x00..0x0F, rx_ready=0 throughout -> exactly OUT_DEPTH strobes issued, rx_data=0x00 held stable; then rx_ready=1 -> the remaining bytes are delivered in order with none lost or duplicated.
4. 128 bytes with random rx_ready (50%) -> output order matches input order, and occupancy + inflight <= OUT_DEPTH in every cycle.
5. Assert reset while 2 strobes are in flight -> next cycle rx_valid=0 and inflight=0; the following byte delivered is the next FIFO entry after the strobed ones.
6. (UART_RX_FIFO_FLUSH_EN) Model FIFO holding 10 bytes, flush for 15 cycles -> fifo_empty=1 and rx_valid=0 afterwards; a new write of 0x55 -> rx_data=0x55 is delivered.
